adc_sample_capture: RTL and testbench
=====================================

# adc_sample_capture

Serial-to-parallel receive stage directly downstream of the ADC SPI sequencer. While the sequencer's `reading` strobe is high, this block shifts in ADC result bits from `sdi`, assembles each complete conversion word, and queues it in a small FIFO. The FIFO drains to the next consumer over a valid/ready handshake. The block also reports truncated frames and FIFO overflow.

## Interface
Parameters:
- `DATA_W`, default 12: bits per conversion frame, and the width of the queued sample.
- `DEPTH`, default 4: FIFO entries; must be a power of two, minimum 2.

Ports:
- `sck`  in  1: clock, the same SPI clock that drives the sequencer.
- `reset`  in  1: synchronous, active-high reset.
- `sdi`  in  1: serial data from the ADC, MSB first.
- `reading`  in  1: high for exactly the bit-capture cycles of a frame, from the sequencer.
- `sample_data`  out  DATA_W: head-of-FIFO sample.
- `sample_valid`  out  1: FIFO is non-empty.
- `sample_ready`  in  1: consumer accepts the head entry when high together with `sample_valid`.
- `overflow`  out  1: sticky; a completed word was dropped because the FIFO was full.
- `frame_err`  out  1: sticky; `reading` fell before `DATA_W` bits were captured.
- `clear_err`  in  1: synchronous clear of `overflow` and `frame_err`.

## Operation
- All state updates on posedge `sck`. The reset condition is evaluated inside the clocked process, not in the sensitivity list.
- Capture FSM:
  - IDLE: waiting for a frame. Moves to SHIFT when `reading`=1, and captures the first bit on that same edge.
  - SHIFT: while `reading`=1, shift left with `sdi` into the LSB and increment `bit_cnt`.
- Frame completion: an edge with `reading`=1 and `bit_cnt`=DATA_W-1 completes the frame.
  - The word is `{shift[DATA_W-2:0], sdi}`.
  - The word is pushed to the FIFO on that edge, and `bit_cnt` returns to 0.
  - The FSM stays in SHIFT if `reading` remains high (back-to-back frame), otherwise it returns to IDLE.
- Truncated frame: `reading`=0 while in SHIFT with `bit_cnt`≠0.
  - Set `frame_err`, discard the partial word, clear `bit_cnt`, go to IDLE.
- FIFO behaviour:
  - Pop occurs when `sample_valid` && `sample_ready`.
  - Push when full: the word is dropped and `overflow` is set. FIFO contents are unchanged.
  - Simultaneous push and pop when full: both succeed and occupancy is unchanged.
  - Simultaneous push and pop when empty: the push succeeds, no pop occurs, occupancy becomes 1.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Occupancy count is `$clog2(DEPTH)+1` bits.
- `clear_err` has priority over a same-edge set, so errors occurring in that cycle are lost.
- Reset values:
  - FSM in IDLE, `bit_cnt`=0, shift register=0.
  - FIFO empty, so `sample_valid`=0 and `sample_data`=0.
  - `overflow`=0, `frame_err`=0.
- Reset while in SHIFT discards the partial frame. Reset has priority over push, pop and `clear_err`.

## Timing
- First-bit capture: the first `reading`=1 edge.
- Latency: `sample_valid` rises after the edge that captures bit DATA_W-1, i.e. visible in the next cycle.
- `sample_data` is driven combinationally from the FIFO head register, with no extra cycle.
- Pop takes effect at the handshake edge. The next entry, or `sample_valid`=0 if none remain, is visible the following cycle.
- Throughput: one word per DATA_W cycles with `reading` held high continuously.

## Configuration
- Macro: `ADC_AVG_EN`.
- Defined:
  - Completed frames accumulate into a DATA_W+2 bit sum.
  - Every 4th completed frame pushes `sum >> 2` (truncating) and clears the sum.
  - Truncated frames do not count toward the four.
  - Reset clears the sum and the frame counter.
- Undefined: every completed frame is pushed raw.

## Structure
- Package `adc_pkg` holds:
  - `ADC_DATA_W` = 12.
  - Capture state enum `cap_state_t` {IDLE, SHIFT}, typed as `logic [0:0]`.
- Sub-module `sample_fifo`: parameterised DATA_W/DEPTH synchronous FIFO with push, pop, full, empty and head outputs. It owns the pointers and occupancy.
- The top level owns the FSM, shifter, error flags and the optional averager.

## Test plan
- Single frame: `reading` high 12 cycles, `sdi` bits of 0xA5C MSB first → `sample_valid`=1 the next cycle, `sample_data`=0xA5C. Pop empties the FIFO (`sample_valid`=0).
- Back-to-back: `reading` high 24 cycles carrying 0x001 then 0xFFF, `sample_ready`=0 → two entries. Pops return 0x001 then 0xFFF in order.
- Overflow: 5 frames with `sample_ready`=0 → 4 entries retained (frames 1–4), `overflow`=1. `clear_err` → `overflow`=0.
- Truncation: `reading` high 7 cycles then low → `frame_err`=1, no push. A following full frame of 0x123 queues 0x123.
- Full push+pop: FIFO full, final bit of a frame coincides with a pop → occupancy stays 4, `overflow`=0, new word at the tail.
- Reset mid-frame after 5 bits → everything cleared. A subsequent frame of 0x800 queues 0x800. With `ADC_AVG_EN`, frames 0x100, 0x200, 0x300, 0x401 → a single push of 0x280.

Source files
------------

// File: rtl/adc_pkg.sv
// adc_pkg: shared constants and types for the ADC receive path.
package adc_pkg;

  localparam int unsigned ADC_DATA_W = 12;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } cap_state_t;

endpackage

// File: rtl/adc_sample_capture_fifo.sv
// sample_fifo: small synchronous FIFO holding completed ADC words.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sample_fifo #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Qualify requests: no pop when empty, push into full only alongside a pop
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/adc_sample_capture.sv
// adc_sample_capture: shifts in ADC result bits while `reading` is high,
// queues each complete word in sample_fifo and flags truncation/overflow.
// Optional feature macro: ADC_AVG_EN (push the average of every 4 frames).
module adc_sample_capture
  import adc_pkg::*;
#(
  parameter int unsigned DATA_W = ADC_DATA_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              sck,
  input  logic              reset,
  input  logic              sdi,
  input  logic              reading,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overflow,
  output logic              frame_err,
  input  logic              clear_err
);

  localparam int unsigned     CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  cap_state_t        state;
  logic [CNT_W-1:0]  bit_cnt;
  // Only the low DATA_W-1 bits are kept; the final bit arrives straight from sdi.
  logic [DATA_W-2:0] shift;
  logic [DATA_W-1:0] word;
  logic              frame_done;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              full;
  logic              empty;

`ifdef ADC_AVG_EN
  localparam int unsigned SUM_W = DATA_W + 2;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] sum_next;
  logic [1:0]       avg_cnt;
`endif

  assign sample_valid = !empty;
  assign pop          = sample_valid && sample_ready;

  // Word assembly and push selection
  always_comb begin
    word       = {shift, sdi};
    frame_done = reading && (bit_cnt == LAST);
`ifdef ADC_AVG_EN
    sum_next  = sum + SUM_W'(word);
    push      = frame_done && (avg_cnt == 2'd3);
    push_data = DATA_W'(sum_next >> 2);
`else
    push      = frame_done;
    push_data = word;
`endif
  end

  // Capture FSM and shifter
  always_ff @(posedge sck) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (reading) begin
            shift   <= word[DATA_W-2:0];
            bit_cnt <= CNT_W'(1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (reading) begin
            shift   <= word[DATA_W-2:0];
            bit_cnt <= frame_done ? '0 : bit_cnt + CNT_W'(1);
          end else begin
            shift   <= '0;
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          shift   <= '0;
        end
      endcase
    end
  end

  // Sticky error flags; clear_err wins over a same-edge set
  always_ff @(posedge sck) begin
    if (reset) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else if (clear_err) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
      if ((state == SHIFT) && !reading && (bit_cnt != '0)) begin
        frame_err <= 1'b1;
      end
    end
  end

`ifdef ADC_AVG_EN
  // Four-frame accumulator; truncated frames never reach frame_done
  always_ff @(posedge sck) begin
    if (reset) begin
      sum     <= '0;
      avg_cnt <= '0;
    end else if (frame_done) begin
      if (avg_cnt == 2'd3) begin
        sum     <= '0;
        avg_cnt <= '0;
      end else begin
        sum     <= sum_next;
        avg_cnt <= avg_cnt + 2'd1;
      end
    end
  end
`endif

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (sck),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (sample_data),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_adc_sample_capture.sv
// tb_adc_sample_capture: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model of the receive stage.
module tb_adc_sample_capture;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned DEPTH  = 4;

  logic              sck = 1'b0;
  logic              reset = 1'b1;
  logic              sdi = 1'b0;
  logic              reading = 1'b0;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready = 1'b0;
  logic              overflow;
  logic              frame_err;
  logic              clear_err = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_q[$];
  int m_acc   = 0;
  int m_nbits = 0;
  int m_ovf   = 0;
  int m_ferr  = 0;
  int m_sum   = 0;
  int m_fcnt  = 0;

  adc_sample_capture #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .sck          (sck),
    .reset        (reset),
    .sdi          (sdi),
    .reading      (reading),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow),
    .frame_err    (frame_err),
    .clear_err    (clear_err)
  );

  initial forever #5 sck = ~sck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the specified behaviour, from pre-edge inputs
  task automatic model_step(input logic rst, input logic rd, input logic d,
                            input logic rdy, input logic clr);
    bit pop_now, full_now, done, push_now, set_ovf, set_ferr;
    int word, pval;
    if (rst) begin
      m_q.delete();
      m_acc = 0; m_nbits = 0; m_ovf = 0; m_ferr = 0; m_sum = 0; m_fcnt = 0;
      return;
    end
    pop_now  = (m_q.size() > 0) && rdy;
    full_now = (m_q.size() == DEPTH);
    done = 0; set_ferr = 0; push_now = 0; set_ovf = 0; word = 0; pval = 0;
    if (rd) begin
      m_acc = m_acc * 2 + int'(d);
      m_nbits++;
      if (m_nbits == DATA_W) begin
        done = 1; word = m_acc; m_acc = 0; m_nbits = 0;
      end
    end else if (m_nbits != 0) begin
      set_ferr = 1; m_acc = 0; m_nbits = 0;
    end
    if (done) begin
`ifdef ADC_AVG_EN
      m_sum += word;
      m_fcnt++;
      if (m_fcnt == 4) begin
        push_now = 1; pval = m_sum / 4; m_sum = 0; m_fcnt = 0;
      end
`else
      push_now = 1; pval = word;
`endif
    end
    if (pop_now) void'(m_q.pop_front());
    if (push_now) begin
      if (full_now && !pop_now) set_ovf = 1;
      else m_q.push_back(pval);
    end
    if (clr) begin
      m_ovf = 0; m_ferr = 0;
    end else begin
      if (set_ovf) m_ovf = 1;
      if (set_ferr) m_ferr = 1;
    end
  endtask

  task automatic cyc(input logic rst, input logic rd, input logic d,
                     input logic rdy, input logic clr);
    reset = rst; reading = rd; sdi = d; sample_ready = rdy; clear_err = clr;
    @(posedge sck);
    model_step(rst, rd, d, rdy, clr);
    #1;
    chk("valid", 32'(sample_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk("data", 32'(sample_data), m_q[0]);
    chk("overflow", 32'(overflow), m_ovf);
    chk("frame_err", 32'(frame_err), m_ferr);
  endtask

  task automatic send_frame(input logic [11:0] w, input logic rdy, input logic rdy_last);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b1, w[11-i], (i == 11) ? rdy_last : rdy, 1'b0);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_data", 32'(sample_data), 32'h0);
    idle(2, 1'b0);

    // Single frame then pop
    send_frame(12'hA5C, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // Back-to-back frames, then drain in order
    send_frame(12'h001, 1'b0, 1'b0);
    send_frame(12'hFFF, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(3, 1'b1);

    // Overflow on the fifth frame, then clear
    for (int f = 0; f < 5; f++) send_frame(12'(12'h111 * (f + 1)), 1'b0, 1'b0);
    idle(1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(5, 1'b1);

    // Truncated frame followed by a good one
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, i[0], 1'b0, 1'b0);
    idle(2, 1'b0);
    send_frame(12'h123, 1'b0, 1'b0);
    idle(2, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Fill, then a final bit coinciding with a pop while full
    for (int f = 0; f < 4; f++) send_frame(12'(12'h0A0 + f), 1'b0, 1'b0);
    send_frame(12'h5A5, 1'b0, 1'b1);
    idle(6, 1'b1);

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    send_frame(12'h800, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Four frames for the averaging path (raw pushes otherwise)
    send_frame(12'h100, 1'b0, 1'b0);
    send_frame(12'h200, 1'b0, 1'b0);
    send_frame(12'h300, 1'b0, 1'b0);
    send_frame(12'h401, 1'b0, 1'b0);
    idle(6, 1'b1);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      cyc(logic'($urandom_range(0, 499) == 0),
          logic'($urandom_range(0, 15) != 0),
          logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 3) == 0),
          logic'($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
